gmii_tx_mux_n: RTL

GMII_TX_MUX_N -- requirements
Module: gmii_tx_mux_n

---
 rtl/gmii_tx_mux_n.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_mux_n
// Purpose  : N-source GMII transmit multiplexer with frame-boundary switching,
//            minimum inter-frame gap enforcement and optional statistics.
//            Statistics counters exist only when GMII_TX_MUX_N_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_mux_n #(
    parameter int  NUM_SRC   = 2,
    parameter int  CNT_WIDTH = 32,
    parameter int  MIN_IFG   = 12,
    localparam int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic [SEL_W-1:0]              sel,
    input  logic [8*NUM_SRC-1:0]          src_txd,
    input  logic [NUM_SRC-1:0]            src_tx_en,
    input  logic [NUM_SRC-1:0]            src_tx_er,
    output logic [7:0]                    gmii_txd,
    output logic                          gmii_tx_en,
    output logic                          gmii_tx_er,
    output logic [SEL_W-1:0]              active_sel,
    output logic                          busy,
    output logic [CNT_WIDTH*NUM_SRC-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam logic [7:0] c_min_ifg = 8'(MIN_IFG);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_active_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         w_gap_nxt;
    logic [7:0]         r_txd;
    logic               r_tx_en;
    logic               r_tx_er;
    logic               w_fwd;
    logic               w_act_en;
    logic               w_act_er;
    logic [7:0]         w_act_txd;
    logic               w_sel_valid;

    always_comb begin
        w_act_en  = 1'b0;
        w_act_er  = 1'b0;
        w_act_txd = 8'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_active_sel == SEL_W'(i)) begin
                w_act_en  = src_tx_en[i];
                w_act_er  = src_tx_er[i];
                w_act_txd = src_txd[8*i +: 8];
            end
        end
    end

    assign w_sel_valid = (32'(sel) < 32'(NUM_SRC));

    // A switch request is only honoured from IDLE, so frames are never cut.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_active_sel;
        w_gap_nxt   = r_gap_cnt;
        w_fwd       = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (!w_act_en) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if ((sel != r_active_sel) && w_sel_valid) begin
                    w_sel_nxt   = sel;
                    w_state_nxt = ST_SYNC;
                end else if (w_act_en) begin
                    w_state_nxt = ST_FRAME;
                    w_fwd       = 1'b1;
                end
            end
            ST_FRAME: begin
                if (w_act_en) begin
                    w_fwd = 1'b1;
                end else begin
                    w_gap_nxt   = 8'd1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_act_en) begin
                    // A restart exactly at the minimum gap is a legal frame start.
                    if (r_gap_cnt >= c_min_ifg) begin
                        w_state_nxt = ST_FRAME;
                        w_fwd       = 1'b1;
                    end else begin
                        w_state_nxt = ST_SYNC;
                    end
                end else if (r_gap_cnt >= c_min_ifg) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state      <= ST_SYNC;
            r_active_sel <= '0;
            r_gap_cnt    <= 8'd0;
            r_txd        <= 8'd0;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_active_sel <= w_sel_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_txd        <= w_fwd ? w_act_txd : 8'd0;
            r_tx_en      <= w_fwd;
            r_tx_er      <= w_fwd & w_act_er;
        end
    end

    assign gmii_txd   = r_txd;
    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = r_tx_er;
    assign active_sel = r_active_sel;
    assign busy       = (r_state != ST_IDLE);

`ifdef GMII_TX_MUX_N_STATS_EN
    logic                 r_sync_first;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic                 w_frame_done;

    assign w_frame_done = (r_state == ST_FRAME) && !w_act_en;

    // Reset lands in SYNC, so the first post-reset cycle counts as a SYNC entry.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_sync_first <= 1'b1;
            r_drop_cnt   <= '0;
        end else begin
            r_sync_first <= (w_state_nxt == ST_SYNC) && (r_state != ST_SYNC);
            if ((r_state == ST_SYNC) && r_sync_first && w_act_en)
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_frame_cnt
        logic [CNT_WIDTH-1:0] r_cnt;
        always_ff @(posedge aclk or negedge arstn) begin
            if (!arstn)
                r_cnt <= '0;
            else if (w_frame_done && (r_active_sel == SEL_W'(i)))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        assign frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule
`default_nettype wire
